imm_gen_pipe: RTL and testbench

- Pipelined successor to the combinational immediate generator.
- Decodes the opcode class and produces the extended immediate for I, D, B, CB and the new IW (MOVZ) formats.
- Carries a sideband tag (typically the PC) alongside each instruction; uses valid/ready handshakes on input and output; supports a pipeline flush; counts illegal opcodes.
- Sits between instruction fetch/decode and the ALU/branch-target path.

---
 rtl/imm_gen_pipe_pkg.sv | 53 +++++
 rtl/imm_gen_pipe_if.sv | 34 +++
 rtl/imm_gen_pipe_extend.sv | 45 ++++
 rtl/imm_gen_pipe.sv | 112 +++++++++++
 tb/tb_imm_gen_pipe.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pkg: shared definitions for the pipelined immediate generator.
//   - Format class codes carried on imm_class.
//   - Opcode prefix masks/values used to classify instr[31:21].
//   - decode_class(): first-match opcode classifier used by stage 1.
package imm_gen_pkg;

    localparam logic [2:0] CLS_NONE = 3'd0;
    localparam logic [2:0] CLS_I    = 3'd1;
    localparam logic [2:0] CLS_D    = 3'd2;
    localparam logic [2:0] CLS_B    = 3'd3;
    localparam logic [2:0] CLS_CB   = 3'd4;
    localparam logic [2:0] CLS_IW   = 3'd5;
    localparam logic [2:0] CLS_ILL  = 3'd7;

    // Prefix matches: (opcode & MASK) == VAL
    localparam logic [10:0] B_MASK   = 11'h7E0;  // opcode[10:5]
    localparam logic [10:0] B_VAL    = 11'h0A0;  // 000101
    localparam logic [10:0] CB_MASK  = 11'h7F0;  // opcode[10:4], covers CBZ and CBNZ
    localparam logic [10:0] CB_VAL   = 11'h5A0;  // 1011010
    localparam logic [10:0] IW_MASK  = 11'h7FC;  // opcode[10:2]
    localparam logic [10:0] IW_VAL   = 11'h694;  // 110100101
    localparam logic [10:0] I_MASK   = 11'h7FE;  // opcode[10:1]
    localparam logic [10:0] ADDI_VAL = 11'h488;  // 1001000100
    localparam logic [10:0] SUBI_VAL = 11'h688;  // 1101000100

    // Exact opcodes
    localparam logic [10:0] OP_LDUR  = 11'h7C2;
    localparam logic [10:0] OP_STUR  = 11'h7C0;
    localparam logic [10:0] OP_ADD   = 11'h458;
    localparam logic [10:0] OP_SUB   = 11'h658;
    localparam logic [10:0] OP_AND   = 11'h450;
    localparam logic [10:0] OP_ORR   = 11'h550;

    // Order of the tests matters: earlier formats win on overlap.
    function automatic logic [2:0] decode_class(input logic [10:0] opcode);
        if ((opcode & B_MASK) == B_VAL)
            return CLS_B;
        else if ((opcode & CB_MASK) == CB_VAL)
            return CLS_CB;
        else if ((opcode & IW_MASK) == IW_VAL)
            return CLS_IW;
        else if (((opcode & I_MASK) == ADDI_VAL) || ((opcode & I_MASK) == SUBI_VAL))
            return CLS_I;
        else if ((opcode == OP_LDUR) || (opcode == OP_STUR))
            return CLS_D;
        else if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
                 (opcode == OP_AND) || (opcode == OP_ORR))
            return CLS_NONE;
        else
            return CLS_ILL;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake bundle for the immediate generator.
//   Input side : flush, in_valid, in_ready, instruction, in_tag
//   Output side: out_valid, out_ready, immediate, imm_class, illegal,
//                out_tag, illegal_count
//   slave  modport: the pipeline itself.
//   master modport: the producer/consumer environment around it.
interface imm_gen_pipe_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 32
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  immediate;
    logic [2:0]             imm_class;
    logic                   illegal;
    logic [TAG_WIDTH-1:0]   out_tag;
    logic [15:0]            illegal_count;

    modport slave (
        input  flush, in_valid, instruction, in_tag, out_ready,
        output in_ready, out_valid, immediate, imm_class, illegal, out_tag, illegal_count
    );

    modport master (
        output flush, in_valid, instruction, in_tag, out_ready,
        input  in_ready, out_valid, immediate, imm_class, illegal, out_tag, illegal_count
    );
endinterface

// File: rtl/imm_gen_pipe_extend.sv
// imm_extend: combinational immediate extension.
//   cls   : format class (imm_gen_pkg CLS_*)
//   instr : 32-bit instruction word
//   imm   : DATA_WIDTH-bit extended immediate
// All arithmetic is done at DATA_WIDTH; IW shifts that push the field past
// DATA_WIDTH simply lose the bits, giving 0 when the shift >= DATA_WIDTH.
module imm_extend
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter bit ALU_SIGNED = 1'b0
) (
    input  logic [2:0]            cls,
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm
);
    logic [DATA_WIDTH-1:0] i_ext;
    logic [DATA_WIDTH-1:0] d_ext;
    logic [DATA_WIDTH-1:0] b_ext;
    logic [DATA_WIDTH-1:0] cb_ext;
    logic [DATA_WIDTH-1:0] iw_ext;
    logic                  unused_bits;

    assign i_ext  = ALU_SIGNED ? {{(DATA_WIDTH-12){instr[21]}}, instr[21:10]}
                               : DATA_WIDTH'(instr[21:10]);
    assign d_ext  = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
    assign b_ext  = {{(DATA_WIDTH-26){instr[25]}}, instr[25:0]};
    assign cb_ext = {{(DATA_WIDTH-19){instr[23]}}, instr[23:5]};
    // hw field selects a 16-bit lane: shift = 16 * instr[22:21]
    assign iw_ext = DATA_WIDTH'(instr[20:5]) << {instr[22:21], 4'b0000};

    assign unused_bits = ^instr[31:26];

    always_comb begin
        imm = '0;
        case (cls)
            CLS_I:   imm = i_ext;
            CLS_D:   imm = d_ext;
            CLS_B:   imm = b_ext << 2;
            CLS_CB:  imm = cb_ext << 2;
            CLS_IW:  imm = iw_ext;
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage pipelined immediate generator.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : imm_gen_pipe_if.slave (input handshake, output handshake,
//           flush and the saturating illegal_count)
// Stage 1 captures instruction, tag and decoded class. Stage 2 captures the
// extended immediate. Each stage advances when its successor is empty or
// being drained, so throughput is one per cycle with two-edge latency.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int TAG_WIDTH   = 32,
    parameter bit ALU_SIGNED  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    imm_gen_pipe_if.slave  bus
);
    logic                   s1_valid_reg;
    logic [INSTR_WIDTH-1:0] s1_instr_reg;
    logic [TAG_WIDTH-1:0]   s1_tag_reg;
    logic [2:0]             s1_class_reg;

    logic                   out_valid_reg;
    logic [DATA_WIDTH-1:0]  imm_reg;
    logic [2:0]             class_reg;
    logic                   illegal_reg;
    logic [TAG_WIDTH-1:0]   tag_reg;
    logic [15:0]            ill_cnt_reg;

    logic                   s2_adv;
    logic                   s1_adv;
    logic                   in_ready;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  ext_imm;

    assign s2_adv   = !out_valid_reg || bus.out_ready;
    assign s1_adv   = s1_valid_reg && s2_adv;
    assign in_ready = !bus.flush && (!s1_valid_reg || s2_adv);
    assign accept   = bus.in_valid && in_ready;

    imm_extend #(
        .DATA_WIDTH (DATA_WIDTH),
        .ALU_SIGNED (ALU_SIGNED)
    ) u_extend (
        .cls   (s1_class_reg),
        .instr (s1_instr_reg[31:0]),
        .imm   (ext_imm)
    );

    // Stage 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_instr_reg <= '0;
            s1_tag_reg   <= '0;
            s1_class_reg <= CLS_NONE;
        end else if (bus.flush) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_instr_reg <= bus.instruction;
            s1_tag_reg   <= bus.in_tag;
            s1_class_reg <= decode_class(bus.instruction[31:21]);
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 2: data only reloads when a real item moves in, so a stalled
    // or empty output holds its last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            imm_reg       <= '0;
            class_reg     <= CLS_NONE;
            illegal_reg   <= 1'b0;
            tag_reg       <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                imm_reg     <= ext_imm;
                class_reg   <= s1_class_reg;
                illegal_reg <= (s1_class_reg == CLS_ILL);
                tag_reg     <= s1_tag_reg;
            end
        end
    end

    // Count illegal results actually handed to the consumer; a flush in the
    // same cycle cancels the transfer, so it is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_cnt_reg <= '0;
        end else if (!bus.flush && out_valid_reg && bus.out_ready && illegal_reg &&
                     (ill_cnt_reg != 16'hFFFF)) begin
            ill_cnt_reg <= ill_cnt_reg + 16'd1;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_reg;
    assign bus.immediate     = imm_reg;
    assign bus.imm_class     = class_reg;
    assign bus.illegal       = illegal_reg;
    assign bus.out_tag       = tag_reg;
    assign bus.illegal_count = ill_cnt_reg;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed sequences plus a randomized stream
// checked against a queue-based reference model of a two-slot pipeline.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .TAG_WIDTH(32)) bus ();
    imm_gen_pipe_if #(.INSTR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(32)) bus32 ();

    imm_gen_pipe #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .TAG_WIDTH(32), .ALU_SIGNED(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    imm_gen_pipe #(.INSTR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(32), .ALU_SIGNED(1'b1)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  cls;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] cnt_exp = 16'd0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    // Reference classifier written straight from the format bit strings.
    function automatic logic [2:0] ref_cls(input logic [31:0] ins);
        logic [10:0] op;
        op = ins[31:21];
        if (op[10:5] == 6'b000101) return 3'd3;
        if (op[10:3] == 8'b10110100 || op[10:3] == 8'b10110101) return 3'd4;
        if (op[10:2] == 9'b110100101) return 3'd5;
        if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100) return 3'd1;
        if (op == 11'b11111000010 || op == 11'b11111000000) return 3'd2;
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return 3'd0;
        return 3'd7;
    endfunction

    // Reference immediate using signed integer arithmetic, then truncated.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int dw, input bit sgn);
        longint v;
        int     sh;
        v = 0;
        case (ref_cls(ins))
            3'd1: begin
                v = longint'(ins[21:10]);
                if (sgn && v >= 2048) v = v - 4096;
            end
            3'd2: begin
                v = longint'(ins[20:12]);
                if (v >= 256) v = v - 512;
            end
            3'd3: begin
                v = longint'(ins[25:0]);
                if (v >= (64'sd1 << 25)) v = v - (64'sd1 << 26);
                v = v * 4;
            end
            3'd4: begin
                v = longint'(ins[23:5]);
                if (v >= (64'sd1 << 18)) v = v - (64'sd1 << 19);
                v = v * 4;
            end
            3'd5: begin
                sh = 16 * int'(ins[22:21]);
                if (sh >= dw) v = 0;
                else          v = longint'(ins[20:5]) << sh;
            end
            default: v = 0;
        endcase
        if (dw < 64) v = v & ((64'sd1 <<< dw) - 1);
        return 64'(v);
    endfunction

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] tg);
        exp_t e;
        e.cls = ref_cls(ins);
        e.imm = ref_imm(ins, 64, 1'b0);
        e.ill = (e.cls == 3'd7);
        e.tag = tg;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {6'b000101, r[25:0]};
            1: return {7'b1011010, r[24:0]};
            2: return {9'b110100101, r[22:0]};
            3: return {(r[31] ? 10'b1001000100 : 10'b1101000100), r[21:0]};
            4: return {(r[31] ? 11'b11111000010 : 11'b11111000000), r[20:0]};
            5: return {(r[31] ? 11'b10001011000 : 11'b10101010000), r[20:0]};
            default: return r;
        endcase
    endfunction

    // One cycle: drive at the falling edge, check against the model, then
    // update the model with what the coming rising edge will do.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic fl,
                        output bit acc, output bit dlv);
        exp_t e;
        bus.in_valid    = v;
        bus.instruction = ins;
        bus.in_tag      = tg;
        bus.out_ready   = ordy;
        bus.flush       = fl;
        acc = 1'b0;
        dlv = 1'b0;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(!fl && (q.size() < 2 || ordy)));
        chk("illegal_count", 64'(bus.illegal_count), 64'(cnt_exp));
        if (q.size() == 0) begin
            chk("out_valid_empty", 64'(bus.out_valid), 64'd0);
        end else if (bus.out_valid) begin
            e = q[0];
            chk("immediate", bus.immediate, e.imm);
            chk("imm_class", 64'(bus.imm_class), 64'(e.cls));
            chk("illegal", 64'(bus.illegal), 64'(e.ill));
            chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
        end
        if (fl) begin
            q.delete();
        end else begin
            if (bus.out_valid && ordy && q.size() > 0) begin
                e = q.pop_front();
                dlv = 1'b1;
                if (e.ill && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
            end
            if (v && bus.in_ready) begin
                q.push_back(mk(ins, tg));
                acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] seq3 [3];
    logic [31:0] ins32 [4];
    logic [63:0] exp32 [4];
    logic [31:0] stall_ins [4];
    bit          acc, dlv;
    int          got, issued;

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.instruction = 0; bus.in_tag = 0; bus.out_ready = 1;
        bus32.flush = 0; bus32.in_valid = 0; bus32.instruction = 0; bus32.in_tag = 0; bus32.out_ready = 1;

        // Reset state
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_immediate", bus.immediate, 64'd0);
        chk("rst_class", 64'(bus.imm_class), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        chk("rst_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_count", 64'(bus.illegal_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Narrow, sign-extending instance
        ins32[0] = 32'hD2C24680; exp32[0] = 64'h0;          // MOVZ hw=2 -> shifted out
        ins32[1] = 32'hD2A24680; exp32[1] = 64'h12340000;   // MOVZ hw=1
        ins32[2] = 32'h913FFC00; exp32[2] = 64'hFFFFFFFF;   // ADDI imm12=0xFFF signed
        ins32[3] = 32'h17FFFFFF; exp32[3] = 64'hFFFFFFFC;   // B -1
        for (int i = 0; i < 6; i++) begin
            bus32.in_valid    = (i < 4);
            bus32.instruction = (i < 4) ? ins32[i] : 32'h0;
            bus32.in_tag      = 32'h100 + i;
            #1;
            if (i >= 2) begin
                chk("w32_valid", 64'(bus32.out_valid), 64'd1);
                chk("w32_imm", 64'(bus32.immediate), exp32[i-2]);
                chk("w32_tag", 64'(bus32.out_tag), 64'(32'h100 + i - 2));
            end
            @(negedge clk);
        end
        bus32.in_valid = 0;

        // ADDI latency
        step(1, 32'h91001441, 32'hCAFE0000, 1, 0, acc, dlv);
        chk("addi_accept", 64'(acc), 64'd1);
        #1 chk("lat_edge1", 64'(bus.out_valid), 64'd0);
        step(0, 0, 0, 0, 0, acc, dlv);
        #1 chk("lat_edge2", 64'(bus.out_valid), 64'd1);
        chk("addi_imm", bus.immediate, 64'd5);
        chk("addi_class", 64'(bus.imm_class), 64'd1);
        step(0, 0, 0, 1, 0, acc, dlv);
        chk("addi_dlv", 64'(dlv), 64'd1);

        // Back-to-back LDUR, B, CBZ
        seq3[0] = 32'hF85F8041; seq3[1] = 32'h17FFFFFF; seq3[2] = 32'hB4000083;
        chk("ldur_model", mk(seq3[0], 0).imm, 64'hFFFFFFFFFFFFFFF8);
        chk("b_model", mk(seq3[1], 0).imm, 64'hFFFFFFFFFFFFFFFC);
        chk("cbz_model", mk(seq3[2], 0).imm, 64'h10);
        for (int i = 0; i < 5; i++) begin
            step(i < 3, (i < 3) ? seq3[i] : 32'h0, 32'h200 + i, 1, 0, acc, dlv);
            if (i >= 2) chk("b2b_consecutive", 64'(dlv), 64'd1);
        end

        // MOVZ on the 64-bit instance
        step(1, 32'hD2C24680, 32'h300, 1, 0, acc, dlv);
        step(0, 0, 0, 1, 0, acc, dlv);
        #1 chk("movz_imm", bus.immediate, 64'h0000123400000000);
        chk("movz_class", 64'(bus.imm_class), 64'd5);
        step(0, 0, 0, 1, 0, acc, dlv);

        // Four items, consumer stalls for three cycles
        stall_ins[0] = 32'h91000C00; stall_ins[1] = 32'hF8400000;
        stall_ins[2] = 32'h14000001; stall_ins[3] = 32'hD2800020;
        got = 0; issued = 0;
        for (int c = 0; c < 20 && (issued < 4 || q.size() > 0); c++) begin
            step(issued < 4, stall_ins[issued % 4], 32'h400 + issued,
                 !(c >= 2 && c <= 4), 0, acc, dlv);
            if (acc) issued++;
            if (dlv) got++;
        end
        chk("stall_delivered", 64'(got), 64'd4);

        // Illegal delivered, then a second illegal flushed in stage 1
        step(1, 32'h00000000, 32'h500, 1, 0, acc, dlv);
        step(0, 0, 0, 1, 0, acc, dlv);
        #1 chk("ill_flag", 64'(bus.illegal), 64'd1);
        chk("ill_class", 64'(bus.imm_class), 64'd7);
        step(1, 32'h00000000, 32'h501, 1, 0, acc, dlv);
        step(0, 0, 0, 1, 1, acc, dlv);
        step(0, 0, 0, 1, 0, acc, dlv);
        step(0, 0, 0, 1, 0, acc, dlv);
        #1 chk("ill_count_one", 64'(bus.illegal_count), 64'd1);

        // Flush with both stages full and a simultaneous offer
        step(1, 32'h91000400, 32'h600, 0, 0, acc, dlv);
        step(1, 32'h91000800, 32'h601, 0, 0, acc, dlv);
        step(1, 32'h91000C00, 32'h602, 0, 1, acc, dlv);
        #1 chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, acc, dlv);

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, acc, dlv);
        end
        for (int i = 0; i < 6 && q.size() > 0; i++) step(0, 0, 0, 1, 0, acc, dlv);
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Asynchronous reset mid-stream
        step(1, 32'h00000000, 32'h700, 1, 0, acc, dlv);
        step(1, 32'h91000400, 32'h701, 0, 0, acc, dlv);
        step(1, 32'h91000800, 32'h702, 0, 0, acc, dlv);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_immediate", bus.immediate, 64'd0);
        chk("mid_rst_class", 64'(bus.imm_class), 64'd0);
        chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
        chk("mid_rst_count", 64'(bus.illegal_count), 64'd0);
        q.delete();
        cnt_exp = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, acc, dlv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
